// File: rtl/panel_entry_if.sv
// Panel bus: key strobes in, entry/address state and the write-request handshake toward cpu_control.
// master = panel_entry side; slave = keyboard/cpu_control/display side.
interface panel_entry_if;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [15:0] entry;
    logic [2:0]  digits;
    logic [15:0] addr;
    logic        wr_req;
    logic [2:0]  wr_sel;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        busy;
    logic        key_dropped;
    logic        wr_err;

    modport master (
        input  key_valid, key_code, wr_ack,
        output entry, digits, addr, wr_req, wr_sel, wr_addr, wr_data, busy, key_dropped, wr_err
    );

    modport slave (
        output key_valid, key_code, wr_ack,
        input  entry, digits, addr, wr_req, wr_sel, wr_addr, wr_data, busy, key_dropped, wr_err
    );
endinterface

// File: rtl/panel_entry.sv
// panel_entry: front-panel key sequencer; optional ack timeout under PANEL_ENTRY_TIMEOUT_EN.
// Latency: key effects next cycle; wr_req rises the cycle after a write key and drops the cycle after wr_ack.
// Backpressure: none on keys; a key arriving while busy is discarded and flagged on key_dropped.
module panel_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    panel_entry_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, POST} state_t;

    state_t      state, state_nxt;
    logic [15:0] entry_q;
    logic [2:0]  digits_q;
    logic [15:0] addr_q;
    logic [2:0]  sel_q;
    logic [15:0] waddr_q;
    logic [15:0] data_q;
    logic        drop_q;

    logic accept, is_hex, is_load, is_store, is_dec, is_reg;
    logic timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("panel_entry: TIMEOUT_CYCLES must be 1..255");
    end

    always_comb begin
        accept   = bus.key_valid && (state == IDLE);
        is_hex   = !bus.key_code[4];
        is_load  = (bus.key_code == 5'h10);
        is_store = (bus.key_code == 5'h11);
        is_dec   = (bus.key_code == 5'h12);
        is_reg   = (bus.key_code >= 5'h13) && (bus.key_code <= 5'h17);
    end

`ifdef PANEL_ENTRY_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err_q;

    // Counter sits at zero outside REQ, so every REQ entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            tcnt  <= (state == REQ) ? tcnt + 8'd1 : 8'd0;
            err_q <= timeout;
        end
    end

    assign timeout    = (state == REQ) && !bus.wr_ack && (tcnt == 8'(TIMEOUT_CYCLES - 1));
    assign bus.wr_err = err_q;
`else
    assign timeout    = 1'b0;
    assign bus.wr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && (is_store || is_reg)) state_nxt = REQ;
            REQ: begin
                if (bus.wr_ack)   state_nxt = POST;
                else if (timeout) state_nxt = IDLE;
            end
            POST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q  <= 16'd0;
            digits_q <= 3'd0;
            addr_q   <= 16'd0;
            sel_q    <= 3'd0;
            waddr_q  <= 16'd0;
            data_q   <= 16'd0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= bus.key_valid && (state != IDLE);
            if (accept) begin
                if (is_hex) begin
                    entry_q <= {entry_q[11:0], bus.key_code[3:0]};
                    if (digits_q != 3'd4) digits_q <= digits_q + 3'd1;
                end else if (is_load) begin
                    addr_q   <= entry_q;
                    entry_q  <= 16'd0;
                    digits_q <= 3'd0;
                end else if (is_dec) begin
                    addr_q <= addr_q - 16'd1;
                end else if (is_store) begin
                    sel_q   <= 3'd5;
                    waddr_q <= addr_q;
                    data_q  <= {8'h00, entry_q[7:0]};
                end else if (is_reg) begin
                    // 0x13..0x17 map onto targets 0..4 by their low three bits.
                    sel_q   <= bus.key_code[2:0] - 3'd3;
                    waddr_q <= 16'd0;
                    data_q  <= (bus.key_code == 5'h17) ? entry_q : {8'h00, entry_q[7:0]};
                end
            end
            if (state == POST) begin
                if (sel_q == 3'd5) begin
                    addr_q <= addr_q + 16'd1;
                end else begin
                    entry_q  <= 16'd0;
                    digits_q <= 3'd0;
                end
            end
        end
    end

    assign bus.entry       = entry_q;
    assign bus.digits      = digits_q;
    assign bus.addr        = addr_q;
    assign bus.wr_req      = (state == REQ);
    assign bus.wr_sel      = sel_q;
    assign bus.wr_addr     = waddr_q;
    assign bus.wr_data     = data_q;
    assign bus.busy        = (state != IDLE);
    assign bus.key_dropped = drop_q;

endmodule

// File: tb/tb_panel_entry.sv
// Bench for panel_entry: directed panel scenarios plus randomized key traffic against a reference model.
module tb_panel_entry;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] addr;
        logic [15:0] data;
        int          len;   // expected wr_req high cycles; 0 = aborted, not checked
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    panel_entry_if bus();

    panel_entry #(.TIMEOUT_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_drops = 0, drops_seen = 0;
    int exp_errs = 0, errs_seen = 0;
    wr_t exp_q[$];

    logic [15:0] m_entry = 16'd0;
    logic [2:0]  m_digits = 3'd0;
    logic [15:0] m_addr = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state();
        chk("entry", 32'(bus.entry), 32'(m_entry));
        chk("digits", 32'(bus.digits), 32'(m_digits));
        chk("addr", 32'(bus.addr), 32'(m_addr));
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_entry", 32'(bus.entry), 32'd0);
        chk("rst_digits", 32'(bus.digits), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
        chk("rst_wr_sel", 32'(bus.wr_sel), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_key_dropped", 32'(bus.key_dropped), 32'd0);
        chk("rst_wr_err", 32'(bus.wr_err), 32'd0);
    endtask

    // Non-write key in IDLE, optionally with a stray ack that must be ignored.
    task automatic press(input logic [4:0] c, input bit stray_ack);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        bus.wr_ack    = stray_ack;
        tick();
        bus.key_valid = 1'b0;
        bus.wr_ack    = 1'b0;
        if (c < 5'h10) begin
            m_entry  = (m_entry << 4) | 16'(c);
            m_digits = (m_digits == 3'd4) ? 3'd4 : m_digits + 3'd1;
        end else if (c == 5'h10) begin
            m_addr   = m_entry;
            m_entry  = 16'd0;
            m_digits = 3'd0;
        end else if (c == 5'h12) begin
            m_addr = m_addr - 16'd1;
        end
        check_state();
    endtask

    function automatic wr_t expect_write(input logic [4:0] c, input int len);
        wr_t e;
        if (c == 5'h11) begin
            e.sel  = 3'd5;
            e.addr = m_addr;
            e.data = {8'h00, m_entry[7:0]};
        end else begin
            e.sel  = 3'(c - 5'h13);
            e.addr = 16'd0;
            e.data = (c == 5'h17) ? m_entry : {8'h00, m_entry[7:0]};
        end
        e.len = len;
        return e;
    endfunction

    // Write key, ack after d request cycles, optional dropped keys mid-request and with the ack.
    task automatic write_cmd(input logic [4:0] c, input int d, input bit dmid, input bit dack);
        exp_q.push_back(expect_write(c, d));
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        tick();
        bus.key_valid = 1'b0;
        for (int i = 1; i < d; i++) begin
            if (dmid && i == 1) begin
                bus.key_valid = 1'b1;
                bus.key_code  = 5'($urandom_range(0, 15));
                exp_drops++;
            end
            tick();
            bus.key_valid = 1'b0;
        end
        bus.wr_ack = 1'b1;
        if (dack) begin
            bus.key_valid = 1'b1;
            bus.key_code  = 5'($urandom_range(0, 18));
            exp_drops++;
        end
        tick();
        bus.wr_ack    = 1'b0;
        bus.key_valid = 1'b0;
        chk("post_wr_req_low", 32'(bus.wr_req), 32'd0);
        tick();
        if (c == 5'h11) begin
            m_addr = m_addr + 16'd1;
        end else begin
            m_entry  = 16'd0;
            m_digits = 3'd0;
        end
        check_state();
    endtask

    // Monitor: pops the scoreboard on each new request and checks hold stability and request length.
    initial begin
        bit  prev = 1'b0;
        int  run  = 0;
        wr_t cur;
        cur.sel = 3'd0; cur.addr = 16'd0; cur.data = 16'd0; cur.len = 0;
        forever begin
            @(negedge clk);
            if (bus.key_dropped) drops_seen++;
            if (bus.wr_err)      errs_seen++;
            if (bus.wr_req) begin
                if (!prev) begin
                    chk("sb_expected_write", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    run = 0;
                end
                chk("wr_sel", 32'(bus.wr_sel), 32'(cur.sel));
                chk("wr_addr", 32'(bus.wr_addr), 32'(cur.addr));
                chk("wr_data", 32'(bus.wr_data), 32'(cur.data));
                run++;
            end else if (prev && cur.len != 0) begin
                chk("wr_req_len", 32'(run), 32'(cur.len));
            end
            prev = bus.wr_req;
        end
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 5'd0;
        bus.wr_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        foreach (bus.key_code[i]) ;
        for (int i = 1; i <= 5; i++) press(5'(i), 1'b0);
        chk("entry_shift_out", 32'(bus.entry), 32'h2345);
        chk("digits_saturate", 32'(bus.digits), 32'd4);

        press(5'h8, 1'b0); press(5'h0, 1'b0); press(5'h0, 1'b0); press(5'h0, 1'b0);
        press(5'h10, 1'b0);
        chk("load_addr", 32'(bus.addr), 32'h8000);
        chk("load_entry_clr", 32'(bus.entry), 32'h0);
        press(5'h0, 1'b0); press(5'h10, 1'b0);
        press(5'h12, 1'b0);
        chk("dec_wrap", 32'(bus.addr), 32'hFFFF);

        press(5'h1, 1'b0); press(5'h2, 1'b0); press(5'hA, 1'b0); press(5'hB, 1'b0);
        chk("pc_write_data", 32'(expect_write(5'h17, 3).data), 32'h12AB);
        write_cmd(5'h17, 3, 1'b0, 1'b0);
        chk("pc_entry_clr", 32'(bus.entry), 32'h0);
        press(5'h1, 1'b0); press(5'h2, 1'b0); press(5'hA, 1'b0); press(5'hB, 1'b0);
        write_cmd(5'h14, 2, 1'b0, 1'b0);
        chk("tox_sel", 32'(bus.wr_sel), 32'd1);
        chk("tox_data", 32'(bus.wr_data), 32'h00AB);

        press(5'h5, 1'b0); press(5'hA, 1'b0);
        write_cmd(5'h11, 1, 1'b0, 1'b0);
        chk("store1_addr", 32'(bus.wr_addr), 32'hFFFF);
        write_cmd(5'h11, 1, 1'b0, 1'b0);
        chk("store2_addr", 32'(bus.wr_addr), 32'h0000);
        chk("store2_data", 32'(bus.wr_data), 32'h005A);
        chk("store_final_addr", 32'(bus.addr), 32'h0001);

        write_cmd(5'h11, 3, 1'b1, 1'b1);
        chk("drop_entry_kept", 32'(bus.entry), 32'h005A);
        chk("drop_count", 32'(drops_seen), 32'd2);

        press(5'h1B, 1'b0);
        press(5'h1F, 1'b1);

`ifdef PANEL_ENTRY_TIMEOUT_EN
        exp_q.push_back(expect_write(5'h11, 10));
        bus.key_valid = 1'b1;
        bus.key_code  = 5'h11;
        tick();
        bus.key_valid = 1'b0;
        repeat (10) tick();
        chk("timeout_wr_err", 32'(bus.wr_err), 32'd1);
        exp_errs++;
        check_state();
`endif

        for (int n = 0; n < 400; n++) begin
            int op = $urandom_range(0, 9);
            if (op <= 3)      press(5'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            else if (op == 4) press(5'h10, 1'b0);
            else if (op == 5) press(5'h12, ($urandom_range(0, 1) == 1));
            else if (op == 6) press(5'($urandom_range(24, 31)), 1'b0);
            else begin
                int d = $urandom_range(1, 4);
                logic [4:0] c = (op == 7) ? 5'h11 : 5'($urandom_range(19, 23));
                write_cmd(c, d, (d >= 2) && ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
            end
            if ($urandom_range(0, 7) == 0) begin
                tick();
                check_state();
            end
        end

        // Reset in the middle of an outstanding request.
        exp_q.push_back(expect_write(5'h13, 0));
        bus.key_valid = 1'b1;
        bus.key_code  = 5'h13;
        tick();
        bus.key_valid = 1'b0;
        tick();
        chk("req_before_reset", 32'(bus.wr_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        m_entry = 16'd0; m_digits = 3'd0; m_addr = 16'd0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        check_state();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("key_dropped_pulses", 32'(drops_seen), 32'(exp_drops));
        chk("wr_err_pulses", 32'(errs_seen), 32'(exp_errs));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
